irq_ctrl: RTL

Interrupt controller sitting directly downstream of the bus devices (timers at 0x7F00–0x7F1F and peers). It collects their IntReq lines and latches them as per-source pending bits, in level or edge mode. It applies a mask and a global enable, and drives a registered HWInt vector into CP0's Cause.IP field. Software reaches it through the bridge as a normal device: four word registers at BASE, combinational read, synchronous write.

---
 rtl/irq_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: per-source pending latch (level/edge), mask, global enable,
// registered HWInt vector to CP0 Cause.IP, four-word bus register file.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high clear of all state
//   Addr     bus byte address (word aligned)
//   DataIn   bus write data
//   We       bus write enable
//   DataOut  combinational read data, 0 on miss or write
//   IrqIn    device IntReq lines, synchronous to clk
//   HWInt    registered masked pending, bits >= NSRC tied 0
module irq_ctrl #(
    parameter int          NSRC = 6,
    parameter logic [31:0] BASE = 32'h0000_7F20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     Addr,
    input  logic [31:0]     DataIn,
    input  logic            We,
    output logic [31:0]     DataOut,
    input  logic [NSRC-1:0] IrqIn,
    output logic [5:0]      HWInt
);

    logic            ge;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] ovf;
    logic [NSRC-1:0] irq_q;
    logic [5:0]      hwint_q;

    logic       hit;
    logic [1:0] sel;
    logic       wr_ctrl;
    logic       wr_mask;
    logic       wr_pend;

    assign hit     = (Addr[31:4] == BASE[31:4]);
    assign sel     = Addr[3:2];
    assign wr_ctrl = hit && We && (sel == 2'd0);
    assign wr_mask = hit && We && (sel == 2'd1);
    assign wr_pend = hit && We && (sel == 2'd2);

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr_p;
    logic [NSRC-1:0] clr_o;
    logic [NSRC-1:0] pend_n;
    logic [NSRC-1:0] ovf_n;
    logic [NSRC-1:0] act;

    // Rises only matter for edge-mode sources; a level source has rise=0.
    assign rise  = mode & IrqIn & ~irq_q;
    assign clr_p = wr_pend ? DataIn[NSRC-1:0] : '0;
    assign clr_o = wr_pend ? DataIn[16 +: NSRC] : '0;

    // Edge: a rise sets PEND and beats any same-cycle clear; a rise on an
    // already pending source records an overflow instead.
    // Level: PEND simply follows the input; its W1C is meaningless.
    assign pend_n = (mode & (rise | (pend & ~clr_p)))
                  | (~mode & IrqIn);
    assign ovf_n  = (rise & (ovf | pend))
                  | (~rise & ovf & ~clr_o);

    assign act = pend & mask;

    logic [5:0]  hw_d;
    logic [2:0]  id_idx;
    logic        any;
    logic [31:0] id_word;
    logic [31:0] ctrl_word;
    logic [31:0] mask_word;
    logic [31:0] pend_word;
    logic [31:0] rdata;

    always_comb begin
        hw_d = '0;
        if (ge) begin
            hw_d[NSRC-1:0] = act;
        end
    end

    // Scan downwards so the lowest active index is the one that sticks.
    always_comb begin
        id_idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                id_idx = 3'(i);
            end
        end
    end

    assign any     = ge && (|act);
    assign id_word = any ? {1'b1, 28'd0, id_idx} : 32'd0;

    always_comb begin
        ctrl_word            = '0;
        ctrl_word[0]         = ge;
        ctrl_word[8 +: NSRC] = mode;
        mask_word            = '0;
        mask_word[NSRC-1:0]  = mask;
        pend_word             = '0;
        pend_word[NSRC-1:0]   = pend;
        pend_word[16 +: NSRC] = ovf;
    end

    always_comb begin
        rdata = '0;
        unique case (sel)
            2'd0: rdata = ctrl_word;
            2'd1: rdata = mask_word;
            2'd2: rdata = pend_word;
            2'd3: rdata = id_word;
            default: rdata = '0;
        endcase
    end

    assign DataOut = (hit && !We) ? rdata : 32'd0;
    assign HWInt   = hwint_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ge      <= 1'b0;
            mode    <= '0;
            mask    <= '0;
            pend    <= '0;
            ovf     <= '0;
            irq_q   <= '0;
            hwint_q <= '0;
        end else begin
            irq_q   <= IrqIn;
            pend    <= pend_n;
            ovf     <= ovf_n;
            hwint_q <= hw_d;
            if (wr_ctrl) begin
                ge   <= DataIn[0];
                mode <= DataIn[8 +: NSRC];
            end
            if (wr_mask) begin
                mask <= DataIn[NSRC-1:0];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{Addr[1:0], DataIn};

endmodule
